nibble_serial_adder: RTL

- Multi-cycle WIDTH-bit adder built on one 4-bit carry-select slice.
- Sits directly upstream of the 4-bit carry-select adder stage and consumes its results:
  - feeds the slice one nibble pair per cycle;
  - captures the slice's sum and carry-out;
  - chains the carry into the next nibble.
- Provides a start/ready/done handshake so wide operands can be added with a small adder footprint.

---
 rtl/nibble_serial_adder_pkg.sv | 29 ++
 rtl/nibble_serial_adder_csel_add4.sv | 22 ++
 rtl/nibble_serial_adder.sv | 113 +++++++++++
 3 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// rtl/nibble_serial_adder_pkg.sv - shared constants, state encoding and ripple helper for nibble_serial_adder
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Bit-level ripple add of two nibbles plus a fixed carry; returns {co, sum}
    function automatic logic [NIBBLE_W:0] ripple4(
        input logic [NIBBLE_W-1:0] x,
        input logic [NIBBLE_W-1:0] y,
        input logic                c
    );
        logic [NIBBLE_W:0] r;
        logic              cy;
        cy = c;
        r  = '0;
        for (int i = 0; i < NIBBLE_W; i++) begin
            r[i] = x[i] ^ y[i] ^ cy;
            cy   = (x[i] & y[i]) | (x[i] & cy) | (y[i] & cy);
        end
        r[NIBBLE_W] = cy;
        return r;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_csel_add4.sv
// rtl/nibble_serial_adder_csel_add4.sv - combinational 4-bit carry-select adder slice (csel_add4)
module csel_add4
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] x,
    input  logic [NIBBLE_W-1:0] y,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] sum,
    output logic                co
);

    logic [NIBBLE_W:0] res_c0;
    logic [NIBBLE_W:0] res_c1;

    // Both carry hypotheses are computed up front; ci only steers the mux
    assign res_c0 = ripple4(x, y, 1'b0);
    assign res_c1 = ripple4(x, y, 1'b1);

    assign sum = ci ? res_c1[NIBBLE_W-1:0] : res_c0[NIBBLE_W-1:0];
    assign co  = ci ? res_c1[NIBBLE_W]     : res_c0[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - multi-cycle WIDTH-bit adder over one csel_add4 slice; optional ovf via NIBBLE_SERIAL_ADDER_OVF_EN
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             done
);

    localparam int NSLICE = WIDTH / NIBBLE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    state_t               state;
    state_t               state_next;
    logic [IDX_W-1:0]     idx;
    logic [WIDTH-1:0]     a_reg;
    logic [WIDTH-1:0]     b_reg;
    logic [WIDTH-1:0]     work_reg;
    logic [WIDTH-1:0]     work_next;
    logic                 carry_reg;
    logic [NIBBLE_W-1:0]  slice_x;
    logic [NIBBLE_W-1:0]  slice_y;
    logic [NIBBLE_W-1:0]  slice_sum;
    logic                 slice_co;
    logic                 last_step;

    assign ready     = (state == IDLE);
    assign last_step = (state == RUN) && (idx == IDX_W'(NSLICE - 1));

    csel_add4 u_slice (
        .x   (slice_x),
        .y   (slice_y),
        .ci  (carry_reg),
        .sum (slice_sum),
        .co  (slice_co)
    );

    // Current nibble pair in, and the work word with this step's nibble merged in
    always_comb begin
        slice_x   = a_reg[int'(idx)*NIBBLE_W +: NIBBLE_W];
        slice_y   = b_reg[int'(idx)*NIBBLE_W +: NIBBLE_W];
        work_next = work_reg;
        work_next[int'(idx)*NIBBLE_W +: NIBBLE_W] = slice_sum;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)     state_next = RUN;
            RUN:     if (last_step) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx       <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            work_reg  <= '0;
            s         <= '0;
            cout      <= 1'b0;
            done      <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            done <= last_step;
            if (state == IDLE) begin
                if (start) begin
                    a_reg     <= a;
                    b_reg     <= b;
                    carry_reg <= cin;
                    idx       <= '0;
                end
            end else begin
                work_reg  <= work_next;
                carry_reg <= slice_co;
                idx       <= idx + IDX_W'(1);
                // Outputs only move on completion so partial sums are never visible
                if (last_step) begin
                    s    <= work_next;
                    cout <= slice_co;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
                    ovf  <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ work_next[WIDTH-1] ^ slice_co;
`endif
                end
            end
        end
    end

endmodule
